sdram_arbit: RTL and testbench

- Command arbiter between the SDRAM sub-controllers (init, auto-refresh, write, read) and the SDRAM pins, 166 MHz domain.
- Consumes the refresh request, refresh end flag and refresh command/bank/address.
- Grants exactly one requester at a time via its enable (aref_en, wr_en, rd_en).
- Muxes the granted source's {cs_n,ras_n,cas_n,we_n}, bank and address onto the device, plus the write-data output enable.

---
 rtl/sdram_arbit.sv | 181 ++++++++++++++++++
 tb/tb_sdram_arbit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter between init, auto-refresh, write and read sub-controllers
//
// Purpose: owns the SDRAM command/bank/address pins. The init block drives them
// until init_end; afterwards a fixed-priority arbiter (refresh > write > read)
// grants one requester at a time. A grant ends on that requester's end pulse
// or, if it never arrives, on a watchdog timeout that raises a sticky error.
//
// Ports:
//   sys_clk, sys_rst        clock and synchronous active-high reset
//   init_*                  init-stage end flag and command/bank/address
//   aref_*                  refresh request/end and command/bank/address
//   wr_*                    write request/end, command/bank/address, data + valid
//   rd_*                    read request/end and command/bank/address
//   aref_en, wr_en, rd_en   one-hot grants (all zero outside grant states)
//   sdram_*                 device pins: cke, command, bank, address, dq out + oe
//   err_timeout             sticky grant-timeout flag

module sdram_arbit #(
    parameter logic [10:0] TIMEOUT_MAX = 11'd1023,
    parameter logic [3:0]  NOP         = 4'b0111
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,

    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,

    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_data,

    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,

    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,

    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,

    output logic        err_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARBIT = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        cke_q, cke_d;

    logic        in_grant;
    logic        grant_end;
    logic [3:0]  cmd;

    assign in_grant = (state_q == S_AREF) || (state_q == S_WRITE) || (state_q == S_READ);

    // Only the end flag belonging to the current grant is honoured.
    always_comb begin
        grant_end = 1'b0;
        case (state_q)
            S_AREF:  grant_end = aref_end;
            S_WRITE: grant_end = wr_end;
            S_READ:  grant_end = rd_end;
            default: grant_end = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = in_grant ? cnt_q + 11'd1 : 11'd0;
        cke_d   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (init_end) state_d = S_ARBIT;
            end
            S_ARBIT: begin
                if (aref_req)     state_d = S_AREF;
                else if (wr_req)  state_d = S_WRITE;
                else if (rd_req)  state_d = S_READ;
            end
            S_AREF, S_WRITE, S_READ: begin
                // An end flag on the final counted cycle wins over the watchdog.
                if (grant_end) begin
                    state_d = S_ARBIT;
                end else if (cnt_q == TIMEOUT_MAX) begin
                    state_d = S_ARBIT;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 11'd0;
            err_q   <= 1'b0;
            cke_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cke_q   <= cke_d;
        end
    end

    assign aref_en = (state_q == S_AREF);
    assign wr_en   = (state_q == S_WRITE);
    assign rd_en   = (state_q == S_READ);

    always_comb begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
        case (state_q)
            S_ARBIT: begin
                cmd        = NOP;
                sdram_ba   = 2'b11;
                sdram_addr = 13'h1fff;
            end
            S_AREF: begin
                cmd        = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            S_READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd        = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

    assign sdram_dq_oe  = (state_q == S_WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_data : 16'h0000;

    assign sdram_cke   = cke_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - self-checking bench for sdram_arbit

module tb_sdram_arbit;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_ARBIT = 3'd1;
    localparam logic [2:0] M_AREF  = 3'd2;
    localparam logic [2:0] M_WRITE = 3'd3;
    localparam logic [2:0] M_READ  = 3'd4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end;
    logic [3:0]  init_cmd  = 4'b0010;
    logic [1:0]  init_ba   = 2'b10;
    logic [12:0] init_addr = 13'h0aaa;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd  = 4'b0001;
    logic [1:0]  aref_ba   = 2'b00;
    logic [12:0] aref_addr = 13'h0400;
    logic        wr_req, wr_end, wr_sdram_en;
    logic [3:0]  wr_cmd    = 4'b0100;
    logic [1:0]  wr_ba     = 2'b01;
    logic [12:0] wr_addr   = 13'h0040;
    logic [15:0] wr_data   = 16'ha5a5;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd    = 4'b0101;
    logic [1:0]  rd_ba     = 2'b11;
    logic [12:0] rd_addr   = 13'h0123;

    logic        aref_en, wr_en, rd_en, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe, err_timeout;

    int errors = 0;
    int checks = 0;

    always #3 sys_clk = ~sys_clk;

    sdram_arbit #(.TIMEOUT_MAX(11'd20)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .err_timeout(err_timeout)
    );

    // {rst, init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en}
    typedef struct {
        logic [8:0] in;
        logic [2:0] st;
        logic       cke;
        logic       oe;
        logic       err;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [40:0] observed();
        return {aref_en, wr_en, rd_en, sdram_cke,
                sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out, err_timeout};
    endfunction

    function automatic logic [40:0] model(input logic [2:0] st, input logic cke,
                                          input logic oe, input logic err);
        logic [3:0]  c;
        logic [1:0]  b;
        logic [12:0] a;
        case (st)
            M_ARBIT: begin c = 4'b0111;  b = 2'b11;   a = 13'h1fff;   end
            M_AREF:  begin c = aref_cmd; b = aref_ba; a = aref_addr; end
            M_WRITE: begin c = wr_cmd;   b = wr_ba;   a = wr_addr;   end
            M_READ:  begin c = rd_cmd;   b = rd_ba;   a = rd_addr;   end
            default: begin c = init_cmd; b = init_ba; a = init_addr; end
        endcase
        return {st == M_AREF, st == M_WRITE, st == M_READ, cke, c, b, a,
                oe, (oe ? wr_data : 16'h0000), err};
    endfunction

    task automatic chk(input string nm, input logic [40:0] act, input logic [40:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] v);
        {sys_rst, init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = v;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // From ARBIT with rd_req raised, count READ-grant cycles; optionally pulse
    // rd_end on the 21st granted cycle.
    task automatic read_grant(input logic end_on_21, output int cnt);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        cnt = 0;
        for (int n = 0; n < 100; n++) begin
            rd_end = end_on_21 && (cnt == 20);
            @(negedge sys_clk);
            if (!rd_en) break;
            cnt++;
            tick();
        end
        rd_end = 1'b0;
    endtask

    initial begin
        int cnt;

        vecs[0]  = '{9'b1_0_0_0_0_0_0_0_0, M_IDLE,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{9'b1_0_0_0_0_0_0_0_0, M_IDLE,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{9'b0_0_0_0_0_0_0_0_0, M_IDLE,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{9'b0_0_0_0_0_0_0_0_0, M_IDLE,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{9'b0_1_0_0_0_0_0_0_0, M_IDLE,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{9'b0_1_1_0_1_0_1_0_0, M_ARBIT, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{9'b0_1_1_0_1_0_1_0_0, M_AREF,  1'b1, 1'b0, 1'b0};
        vecs[7]  = '{9'b0_1_0_1_1_0_1_0_0, M_AREF,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{9'b0_1_0_0_1_0_1_0_0, M_ARBIT, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{9'b0_1_0_0_1_0_1_0_1, M_WRITE, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{9'b0_1_0_1_1_0_1_1_0, M_WRITE, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{9'b0_1_1_0_1_0_1_0_1, M_WRITE, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{9'b0_1_1_0_1_1_1_0_1, M_WRITE, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{9'b0_1_1_0_1_0_1_0_0, M_ARBIT, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{9'b0_1_0_1_0_0_1_0_1, M_AREF,  1'b1, 1'b0, 1'b0};
        vecs[15] = '{9'b0_1_0_0_0_0_1_0_1, M_ARBIT, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{9'b0_0_0_0_0_0_1_1_1, M_READ,  1'b1, 1'b0, 1'b0};
        vecs[17] = '{9'b0_0_0_0_0_0_0_0_0, M_ARBIT, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{9'b0_0_0_0_0_0_0_0_0, M_ARBIT, 1'b1, 1'b0, 1'b0};

        drive(9'b1_0_0_0_0_0_0_0_0);
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].in);
            @(negedge sys_clk);
            chk($sformatf("vec%0d", i), observed(),
                model(vecs[i].st, vecs[i].cke, vecs[i].oe, vecs[i].err));
            tick();
        end

        // Watchdog expiry: grant lasts TIMEOUT_MAX+1 cycles, then sticky error.
        read_grant(1'b0, cnt);
        chk("timeout_cycles", 41'(cnt), 41'd21);
        chk("timeout_arbit", observed(), model(M_ARBIT, 1'b1, 1'b0, 1'b1));
        tick();
        tick();
        @(negedge sys_clk);
        chk("timeout_sticky", observed(), model(M_ARBIT, 1'b1, 1'b0, 1'b1));

        // Reset while refresh is granted.
        tick();
        aref_req = 1'b1;
        tick();
        aref_req = 1'b0;
        @(negedge sys_clk);
        chk("aref_granted", observed(), model(M_AREF, 1'b1, 1'b0, 1'b1));
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("reset_mid_grant", observed(), model(M_IDLE, 1'b0, 1'b0, 1'b0));

        // End flag on the last counted cycle is a normal completion.
        tick();
        init_end = 1'b1;
        tick();
        @(negedge sys_clk);
        chk("rerun_arbit", observed(), model(M_ARBIT, 1'b1, 1'b0, 1'b0));
        tick();
        read_grant(1'b1, cnt);
        chk("end_at_limit_cycles", 41'(cnt), 41'd21);
        chk("end_at_limit_noerr", observed(), model(M_ARBIT, 1'b1, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
